// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard controller.
// The datapath side (master) supplies the IF/ID instruction and branch outcome; the controller (slave) returns enables and selects.
interface pipeline_hazard_controller_if;
    logic [31:0] id_instruction;
    logic        id_valid;
    logic        branch_taken;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        halted;
    logic [1:0]  state;

    modport master (
        output id_instruction, id_valid, branch_taken,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
        input  fwd_a, fwd_b, halted, state
    );

    modport slave (
        input  id_instruction, id_valid, branch_taken,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble,
        output fwd_a, fwd_b, halted, state
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for a 5-stage MIPS pipeline: load-use stalls, branch flushes,
// EX operand forwarding selects and the halt drain sequence.
module pipeline_hazard_controller #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pipeline_hazard_controller_if.slave   hz
);
    localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       load;
    } sb_entry_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               halted_reg;
    logic [1:0]         fwd_a_reg;
    logic [1:0]         fwd_b_reg;
    sb_entry_t          sb_reg [0:2];   // 0 = EX, 1 = MEM, 2 = WB

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  dec_dest;
    logic        dec_writes;
    logic        dec_load;
    logic        uses_rs;
    logic        uses_rt;
    logic        is_halt;

    logic        in_run;
    logic        load_use;
    logic        flush;
    logic        halt_accept;
    logic        issue;
    sb_entry_t   ex_entry_next;

    always_comb begin
        op         = hz.id_instruction[31:26];
        rs         = hz.id_instruction[25:21];
        rt         = hz.id_instruction[20:16];
        rd         = hz.id_instruction[15:11];
        dec_dest   = 5'd0;
        dec_load   = 1'b0;
        dec_writes = 1'b0;
        case (op)
            6'h00: begin
                dec_dest   = rd;
                dec_writes = 1'b1;
            end
            6'h23: begin
                dec_dest   = rt;
                dec_load   = 1'b1;
                dec_writes = 1'b1;
            end
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                dec_dest   = rt;
                dec_writes = 1'b1;
            end
            6'h03: begin
                dec_dest   = 5'd31;
                dec_writes = 1'b1;
            end
            default: begin
                dec_writes = 1'b0;
            end
        endcase
        // $0 is hard-wired, so a write to it never creates a dependency
        if (dec_dest == 5'd0) begin
            dec_writes = 1'b0;
        end
        uses_rs = !(op == 6'h02 || op == 6'h03 || op == 6'h0F);
        uses_rt = (op == 6'h00 || op == 6'h2B || op == 6'h04 || op == 6'h05);
        is_halt = (hz.id_instruction == 32'hFFFF_FFFF);
    end

    // Scoreboard entries only ever hold valid=1 with a non-zero destination.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                           input sb_entry_t ex,
                                           input sb_entry_t mem);
        logic [1:0] sel;
        sel = 2'b00;
        if (r != 5'd0 && ex.valid && ex.dest == r) begin
            sel = 2'b10;
        end else if (r != 5'd0 && mem.valid && mem.dest == r) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        in_run   = (state_reg == ST_RUN);
        load_use = in_run && hz.id_valid && sb_reg[0].valid && sb_reg[0].load &&
                   ((uses_rs && rs == sb_reg[0].dest) || (uses_rt && rt == sb_reg[0].dest));
        flush       = in_run && hz.branch_taken;
        halt_accept = in_run && hz.id_valid && is_halt && !flush && !load_use;
        issue       = in_run && hz.id_valid && !is_halt && !flush && !load_use;

        ex_entry_next = '0;
        if (issue && dec_writes) begin
            ex_entry_next.valid = 1'b1;
            ex_entry_next.dest  = dec_dest;
            ex_entry_next.load  = dec_load;
        end
    end

    // The front end is also frozen on the halt-accept cycle so fetch never runs past the halt word.
    always_comb begin
        hz.pc_write     = 1'b1;
        hz.if_id_write  = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_bubble = 1'b0;
        if (!in_run) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.id_ex_bubble = 1'b1;
        end else if (flush) begin
            hz.if_id_flush  = 1'b1;
            hz.id_ex_bubble = 1'b1;
        end else if (load_use || halt_accept) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_RUN;
            cnt_reg    <= '0;
            halted_reg <= 1'b0;
            fwd_a_reg  <= 2'b00;
            fwd_b_reg  <= 2'b00;
            for (int i = 0; i < 3; i++) begin
                sb_reg[i] <= '0;
            end
        end else begin
            fwd_a_reg <= issue ? fwd_sel(rs, sb_reg[0], sb_reg[1]) : 2'b00;
            fwd_b_reg <= issue ? fwd_sel(rt, sb_reg[0], sb_reg[1]) : 2'b00;

            sb_reg[0] <= ex_entry_next;
            for (int i = 1; i < 3; i++) begin
                sb_reg[i] <= (state_reg == ST_HALTED) ? '0 : sb_reg[i-1];
            end

            case (state_reg)
                ST_RUN: begin
                    if (halt_accept) begin
                        state_reg <= ST_DRAIN;
                        cnt_reg   <= '0;
                    end
                end
                ST_DRAIN: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        state_reg  <= ST_HALTED;
                        halted_reg <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    state_reg  <= ST_HALTED;
                    halted_reg <= 1'b1;
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

    assign hz.fwd_a  = fwd_a_reg;
    assign hz.fwd_b  = fwd_b_reg;
    assign hz.halted = halted_reg;
    assign hz.state  = state_reg;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: the driver pushes the model's expected response for each cycle,
// the monitor pops and compares on the falling edge.
module tb_pipeline_hazard_controller;
    localparam int DRAIN_CYCLES = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if hif();

    pipeline_hazard_controller #(.DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif.slave)
    );

    typedef struct {
        bit    pc;
        bit    ifid;
        bit    flush;
        bit    bubble;
        int    fa;
        int    fb;
        int    st;
        bit    halted;
        string tag;
    } exp_t;

    typedef struct {
        bit v;
        int dest;
        bit load;
    } slot_t;

    typedef struct {
        int dest;      // -1 when nothing is written
        bit load;
        int rs;
        int rt;
        int rs_src;    // -1 when not read
        int rt_src;
        bit halt;
    } dec_t;

    exp_t  exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model: in-flight writers (index 0 = EX, 1 = MEM, 2 = WB), mode 0/1/2 = run/drain/halted
    slot_t pipe[$];
    int    mode;
    int    drain_left;
    int    m_fa;
    int    m_fb;

    function automatic void model_reset();
        slot_t nul;
        nul = '{v: 1'b0, dest: 0, load: 1'b0};
        mode = 0;
        drain_left = 0;
        m_fa = 0;
        m_fb = 0;
        pipe.delete();
        repeat (3) pipe.push_back(nul);
    endfunction

    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        int op;
        int rd;
        op = int'(w[31:26]);
        rd = int'(w[15:11]);
        d.rs = int'(w[25:21]);
        d.rt = int'(w[20:16]);
        d.load = 1'b0;
        d.dest = -1;
        case (op)
            'h00: d.dest = rd;
            'h23: begin d.dest = d.rt; d.load = 1'b1; end
            'h08, 'h09, 'h0A, 'h0C, 'h0D, 'h0E, 'h0F: d.dest = d.rt;
            'h03: d.dest = 31;
            default: d.dest = -1;
        endcase
        if (d.dest == 0) d.dest = -1;
        d.rs_src = (op == 'h02 || op == 'h03 || op == 'h0F) ? -1 : d.rs;
        d.rt_src = (op == 'h00 || op == 'h2B || op == 'h04 || op == 'h05) ? d.rt : -1;
        d.halt = (w == 32'hFFFF_FFFF);
        return d;
    endfunction

    function automatic int fwd_of(input int r);
        if (r != 0 && pipe[0].v && pipe[0].dest == r) return 2;
        if (r != 0 && pipe[1].v && pipe[1].dest == r) return 1;
        return 0;
    endfunction

    // Called at posedge+1; drives one cycle of input, queues the expectation, advances the model.
    task automatic cycle(input string tag, input logic [31:0] w, input bit v, input bit br);
        dec_t  d;
        exp_t  e;
        slot_t ns;
        bit    run, lu, fl, ha, iss;
        hif.id_instruction = w;
        hif.id_valid       = v;
        hif.branch_taken   = br;
        d   = decode(w);
        run = (mode == 0);
        lu  = run && v && pipe[0].v && pipe[0].load &&
              (d.rs_src == pipe[0].dest || d.rt_src == pipe[0].dest);
        fl  = run && br;
        ha  = run && v && d.halt && !fl && !lu;
        e.pc     = run && (fl || !(lu || ha));
        e.ifid   = e.pc;
        e.flush  = fl;
        e.bubble = !run || fl || lu || ha;
        e.fa     = m_fa;
        e.fb     = m_fb;
        e.st     = mode;
        e.halted = (mode == 2);
        e.tag    = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            iss  = run && v && !d.halt && !fl && !lu;
            m_fa = iss ? fwd_of(d.rs) : 0;
            m_fb = iss ? fwd_of(d.rt) : 0;
            ns.v    = iss && (d.dest > 0);
            ns.dest = ns.v ? d.dest : 0;
            ns.load = ns.v && d.load;
            pipe.push_front(ns);
            void'(pipe.pop_back());
            if (mode == 1) begin
                drain_left--;
                if (drain_left == 0) mode = 2;
            end
            if (ha) begin
                mode = 1;
                drain_left = DRAIN_CYCLES;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        cycle("reset", 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("[%0t] %-8s pc=%0d ifid=%0d fl=%0d bub=%0d fa=%0d fb=%0d st=%0d h=%0d",
                         $time, e.tag, hif.pc_write, hif.if_id_write, hif.if_id_flush,
                         hif.id_ex_bubble, hif.fwd_a, hif.fwd_b, hif.state, hif.halted);
                chk({e.tag, ".pc_write"},     int'(hif.pc_write),     int'(e.pc));
                chk({e.tag, ".if_id_write"},  int'(hif.if_id_write),  int'(e.ifid));
                chk({e.tag, ".if_id_flush"},  int'(hif.if_id_flush),  int'(e.flush));
                chk({e.tag, ".id_ex_bubble"}, int'(hif.id_ex_bubble), int'(e.bubble));
                chk({e.tag, ".fwd_a"},        int'(hif.fwd_a),        e.fa);
                chk({e.tag, ".fwd_b"},        int'(hif.fwd_b),        e.fb);
                chk({e.tag, ".state"},        int'(hif.state),        e.st);
                chk({e.tag, ".halted"},       int'(hif.halted),       int'(e.halted));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] rand_instr();
        int ops[10] = '{'h00, 'h23, 'h2B, 'h04, 'h05, 'h08, 'h0D, 'h0F, 'h02, 'h03};
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        op = 6'(ops[$urandom_range(0, 9)]);
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        return {op, rs, rt, rd, 11'h020};
    endfunction

    initial begin
        hif.id_instruction = 32'h0;
        hif.id_valid       = 1'b0;
        hif.branch_taken   = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        repeat (3) cycle("reset", 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cycle("idle", 32'h0, 1'b0, 1'b0);

        // EX/MEM forward
        cycle("add9",  32'h014B_4820, 1'b1, 1'b0);
        cycle("add10", 32'h012B_5020, 1'b1, 1'b0);
        cycle("exfwd", 32'h0, 1'b0, 1'b0);
        cycle("idle",  32'h0, 1'b0, 1'b0);

        // Load-use stall then MEM/WB forward
        cycle("lw9",    32'h8D09_0000, 1'b1, 1'b0);
        cycle("lu_stl", 32'h012B_5020, 1'b1, 1'b0);
        cycle("lu_iss", 32'h012B_5020, 1'b1, 1'b0);
        cycle("memfwd", 32'h0, 1'b0, 1'b0);

        // Load to $0 never stalls
        cycle("lw0",    32'h8D00_0000, 1'b1, 1'b0);
        cycle("use0",   32'h0000_5020, 1'b1, 1'b0);
        cycle("idle",   32'h0, 1'b0, 1'b0);

        // Flush beats load-use
        cycle("lw9",    32'h8D09_0000, 1'b1, 1'b0);
        cycle("flush",  32'h012B_5020, 1'b1, 1'b1);
        cycle("postfl", 32'h012B_5020, 1'b1, 1'b0);
        cycle("idle",   32'h0, 1'b0, 1'b0);

        // Halt squashed by a branch stays in RUN
        cycle("haltbr", 32'hFFFF_FFFF, 1'b1, 1'b1);
        cycle("idle",   32'h0, 1'b0, 1'b0);

        // Halt drain and hold; branches during drain ignored
        cycle("lw9",  32'h8D09_0000, 1'b1, 1'b0);
        cycle("halt", 32'hFFFF_FFFF, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) cycle("drain", 32'h012B_5020, 1'b1, 1'(i % 2));
        do_reset();

        // Reset asserted in the second drain cycle
        cycle("halt",  32'hFFFF_FFFF, 1'b1, 1'b0);
        cycle("drain", 32'h0, 1'b1, 1'b0);
        rst_n = 1'b0;
        model_reset();
        cycle("rstmid", 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cycle("idle", 32'h0, 1'b0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] w;
            if (mode == 2 && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else begin
                w = ($urandom_range(0, 59) == 0) ? 32'hFFFF_FFFF : rand_instr();
                cycle("rand", w, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10);
            end
        end

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_queue: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
